chess_board_store: RTL and testbench

- Parametrised board-state store and move executor.
- Holds one piece code per square, loads the start position autonomously after reset or on request, and executes single src->dst moves through a req/done handshake.
- Provides a registered read port for the display and input logic.
- Sits between the button/cursor controller (move requests) and the VGA renderer (read port).

---
 rtl/chess_board_store.sv | 259 +++++++++++++++++++++++++
 tb/tb_chess_board_store.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_board_store.sv
// ---------------------------------------------------------------------------
// chess_board_store
//
// Board-state store and single-move executor for the chess game. Holds one
// 4-bit piece code {color, type[2:0]} per square, writes the start position
// after reset or on clear_req, and executes src->dst moves through a
// req/done handshake. A registered read port serves the renderer.
//
// Optional feature macro: CHESS_BOARD_UNDO_EN (one-level undo history).
//
// Ports:
//   ClkPort     in   system clock
//   Reset       in   asynchronous active-low reset
//   clear_req   in   re-initialise the board (sampled in IDLE only)
//   init_busy   out  start position being written
//   move_ready  out  high only in IDLE
//   move_req    in   start a move (sampled when move_ready=1)
//   move_src    in   source square {row, col}
//   move_dst    in   destination square {row, col}
//   move_done   out  one-cycle completion pulse
//   move_err    out  1 = move rejected, board unchanged (valid with move_done)
//   captured    out  piece previously on dst (valid with move_done)
//   rd_addr     in   display/query square
//   rd_data     out  piece at rd_addr, one-cycle latency
//   undo_req    in   (CHESS_BOARD_UNDO_EN) undo the last legal move
//   undo_valid  out  (CHESS_BOARD_UNDO_EN) history holds an undoable move
// ---------------------------------------------------------------------------
module chess_board_store #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
) (
  input  logic                         ClkPort,
  input  logic                         Reset,
  input  logic                         clear_req,
  output logic                         init_busy,
  output logic                         move_ready,
  input  logic                         move_req,
  input  logic [ROW_BITS+COL_BITS-1:0] move_src,
  input  logic [ROW_BITS+COL_BITS-1:0] move_dst,
  output logic                         move_done,
  output logic                         move_err,
  output logic [3:0]                   captured,
  input  logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  output logic [3:0]                   rd_data
`ifdef CHESS_BOARD_UNDO_EN
  ,
  input  logic                         undo_req,
  output logic                         undo_valid
`endif
);

  localparam int SQ_W   = ROW_BITS + COL_BITS;
  localparam int NUM_SQ = 2 ** SQ_W;
  localparam int ROWS   = 2 ** ROW_BITS;

  localparam logic [ROW_BITS-1:0] ROW_WHITE_PAWN = ROW_BITS'(ROWS - 2);
  localparam logic [ROW_BITS-1:0] ROW_WHITE_BACK = ROW_BITS'(ROWS - 1);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    MV_RD  = 3'd2,
    MV_WR  = 3'd3,
    MV_CLR = 3'd4,
    DONE   = 3'd5,
    UN_SRC = 3'd6,
    UN_DST = 3'd7
  } stateT;

  stateT            state, stateNext;
  logic [SQ_W-1:0]  initCnt;
  logic [SQ_W-1:0]  srcSq, dstSq;
  logic [3:0]       srcPiece, dstPiece;
  logic             moveIllegal;
  logic             errNext;
  logic [3:0]       capNext;

  logic             wrEn;
  logic [SQ_W-1:0]  wrAddr;
  logic [3:0]       wrData;

  logic [3:0]       board [0:NUM_SQ-1];

`ifdef CHESS_BOARD_UNDO_EN
  logic [SQ_W-1:0]  histSrc, histDst;
  logic [3:0]       histMoved, histCaptured;
`endif

  // Start-position piece for a square; back-rank order repeats every 8 columns.
  function automatic logic [3:0] startPiece(input logic [SQ_W-1:0] sq);
    logic [ROW_BITS-1:0] row;
    logic [2:0]          col8;
    logic [2:0]          backType;
    row  = sq[SQ_W-1:COL_BITS];
    col8 = 3'(sq[COL_BITS-1:0]);
    case (col8)
      3'd0:    backType = 3'b100;  // rook
      3'd1:    backType = 3'b010;  // knight
      3'd2:    backType = 3'b011;  // bishop
      3'd3:    backType = 3'b101;  // queen
      3'd4:    backType = 3'b110;  // king
      3'd5:    backType = 3'b011;  // bishop
      3'd6:    backType = 3'b010;  // knight
      default: backType = 3'b100;  // rook
    endcase
    if (row == '0)                  startPiece = {1'b1, backType};
    else if (row == ROW_BITS'(1))   startPiece = 4'b1001;
    else if (row == ROW_WHITE_PAWN) startPiece = 4'b0001;
    else if (row == ROW_WHITE_BACK) startPiece = {1'b0, backType};
    else                            startPiece = 4'b0000;
  endfunction

  // Rejection rules: null move, empty source, or landing on an own piece.
  assign moveIllegal = (srcSq == dstSq) ||
                       (srcPiece[2:0] == 3'b000) ||
                       ((srcPiece[3] == dstPiece[3]) && (dstPiece[2:0] != 3'b000));

  assign init_busy  = (state == INIT);
  assign move_ready = (state == IDLE);
  assign move_done  = (state == DONE);

  // Next-state, write-port and result selection.
  always_comb begin
    stateNext = state;
    wrEn      = 1'b0;
    wrAddr    = initCnt;
    wrData    = 4'b0000;
    errNext   = 1'b0;
    capNext   = captured;
    case (state)
      INIT: begin
        wrEn   = 1'b1;
        wrAddr = initCnt;
        wrData = startPiece(initCnt);
        if (initCnt == '1) stateNext = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          stateNext = INIT;
        end
`ifdef CHESS_BOARD_UNDO_EN
        else if (undo_req) begin
          if (undo_valid) begin
            stateNext = UN_SRC;
          end else begin
            stateNext = DONE;
            errNext   = 1'b1;
            capNext   = 4'b0000;
          end
        end
`endif
        else if (move_req) begin
          stateNext = MV_RD;
        end
      end
      MV_RD: begin
        if (moveIllegal) begin
          stateNext = DONE;
          errNext   = 1'b1;
          capNext   = 4'b0000;
        end else begin
          stateNext = MV_WR;
        end
      end
      MV_WR: begin
        wrEn      = 1'b1;
        wrAddr    = dstSq;
        wrData    = srcPiece;
        stateNext = MV_CLR;
      end
      MV_CLR: begin
        wrEn      = 1'b1;
        wrAddr    = srcSq;
        wrData    = 4'b0000;
        stateNext = DONE;
        errNext   = 1'b0;
        capNext   = dstPiece;
      end
`ifdef CHESS_BOARD_UNDO_EN
      UN_SRC: begin
        wrEn      = 1'b1;
        wrAddr    = histSrc;
        wrData    = histMoved;
        stateNext = UN_DST;
      end
      UN_DST: begin
        wrEn      = 1'b1;
        wrAddr    = histDst;
        wrData    = histCaptured;
        stateNext = DONE;
        errNext   = 1'b0;
        capNext   = 4'b0000;
      end
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = INIT;
    endcase
  end

  // Board array: single write port, no reset (INIT rewrites every square).
  always_ff @(posedge ClkPort) begin
    if (wrEn) board[wrAddr] <= wrData;
  end

  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      state    <= INIT;
      initCnt  <= '0;
      srcSq    <= '0;
      dstSq    <= '0;
      srcPiece <= 4'b0000;
      dstPiece <= 4'b0000;
      move_err <= 1'b0;
      captured <= 4'b0000;
      rd_data  <= 4'b0000;
    end else begin
      state   <= stateNext;
      // Same-cycle write to rd_addr is not forwarded: the old value is returned.
      rd_data <= board[rd_addr];
      if (state == INIT) initCnt <= initCnt + 1'b1;  // wraps to 0 on exit
      if (state == IDLE && clear_req) initCnt <= '0;
      // Source and destination are read on acceptance so both pieces are
      // available for the legality check in MV_RD.
      if (state == IDLE && stateNext == MV_RD) begin
        srcSq    <= move_src;
        dstSq    <= move_dst;
        srcPiece <= board[move_src];
        dstPiece <= board[move_dst];
      end
      // Results only change when a new completion is signalled.
      if (stateNext == DONE) begin
        move_err <= errNext;
        captured <= capNext;
      end
    end
  end

`ifdef CHESS_BOARD_UNDO_EN
  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      histSrc      <= '0;
      histDst      <= '0;
      histMoved    <= 4'b0000;
      histCaptured <= 4'b0000;
      undo_valid   <= 1'b0;
    end else begin
      if (state == MV_RD && !moveIllegal) begin
        histSrc      <= srcSq;
        histDst      <= dstSq;
        histMoved    <= srcPiece;
        histCaptured <= dstPiece;
        undo_valid   <= 1'b1;
      end
      if (state == UN_DST || state == INIT) undo_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_chess_board_store.sv
// ---------------------------------------------------------------------------
// tb_chess_board_store
//
// Directed self-checking bench for chess_board_store (default 8x8 board).
// Each scenario task drives its stimulus and checks results inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_chess_board_store;

  logic       ClkPort = 1'b0;
  logic       Reset = 1'b0;
  logic       clear_req = 1'b0;
  logic       move_req = 1'b0;
  logic [5:0] move_src = 6'd0;
  logic [5:0] move_dst = 6'd0;
  logic [5:0] rd_addr = 6'd0;
  logic       init_busy, move_ready, move_done, move_err;
  logic [3:0] captured, rd_data;
`ifdef CHESS_BOARD_UNDO_EN
  logic       undo_req = 1'b0;
  logic       undo_valid;
`endif

  int checks = 0;
  int fails  = 0;

  chess_board_store dut (
    .ClkPort    (ClkPort),
    .Reset      (Reset),
    .clear_req  (clear_req),
    .init_busy  (init_busy),
    .move_ready (move_ready),
    .move_req   (move_req),
    .move_src   (move_src),
    .move_dst   (move_dst),
    .move_done  (move_done),
    .move_err   (move_err),
    .captured   (captured),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
`ifdef CHESS_BOARD_UNDO_EN
    ,
    .undo_req   (undo_req),
    .undo_valid (undo_valid)
`endif
  );

  always #5 ClkPort = ~ClkPort;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Registered read: present address, sample one edge later.
  task automatic read_sq(input logic [5:0] a, output logic [3:0] d);
    @(negedge ClkPort);
    rd_addr = a;
    @(posedge ClkPort);
    #1;
    d = rd_data;
  endtask

  // Count edges until init_busy drops (bounded).
  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge ClkPort);
      #1;
      n++;
    end while (init_busy && n < 200);
  endtask

  // Issue one request (move or undo) from IDLE; lat counts edges from the
  // accepting edge (1) to the edge after which move_done is seen.
  task automatic run_op(input bit isUndo, input logic [5:0] src, input logic [5:0] dst,
                        output int lat, output logic err, output logic [3:0] cap,
                        output logic readyAfter, output logic doneAfter);
    @(negedge ClkPort);
    move_src = src;
    move_dst = dst;
    if (isUndo) begin
`ifdef CHESS_BOARD_UNDO_EN
      undo_req = 1'b1;
`endif
    end else begin
      move_req = 1'b1;
    end
    lat = 0;
    do begin
      @(posedge ClkPort);
      #1;
      lat++;
      move_req = 1'b0;
`ifdef CHESS_BOARD_UNDO_EN
      undo_req = 1'b0;
`endif
    end while (!move_done && lat < 20);
    err = move_err;
    cap = captured;
    @(posedge ClkPort);
    #1;
    readyAfter = move_ready;
    doneAfter  = move_done;
    $display("op undo=%0d src=%0d dst=%0d lat=%0d err=%0b captured=%b", isUndo, src, dst, lat, err, cap);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (init_busy !== 1'b1) begin fails++; $display("FAIL reset_init_busy: got %b expected 1", init_busy); end
    checks++; if (move_ready !== 1'b0) begin fails++; $display("FAIL reset_move_ready: got %b expected 0", move_ready); end
    checks++; if (move_done !== 1'b0) begin fails++; $display("FAIL reset_move_done: got %b expected 0", move_done); end
    checks++; if (move_err !== 1'b0) begin fails++; $display("FAIL reset_move_err: got %b expected 0", move_err); end
    checks++; if (captured !== 4'b0000) begin fails++; $display("FAIL reset_captured: got %b expected 0000", captured); end
    checks++; if (rd_data !== 4'b0000) begin fails++; $display("FAIL reset_rd_data: got %b expected 0000", rd_data); end
    $display("reset checked");
  endtask

  task automatic test_init();
    int n;
    logic [3:0] d;
    logic [5:0] addrs [4] = '{6'b111_100, 6'b000_011, 6'b001_000, 6'b100_000};
    logic [3:0] exps  [4] = '{4'b0110,    4'b1101,    4'b1001,    4'b0000};
    @(negedge ClkPort);
    Reset = 1'b1;
    wait_init(n);
    $display("init finished after %0d cycles", n);
    checks++; if (n !== 64) begin fails++; $display("FAIL init_cycles: got %0d expected 64", n); end
    checks++; if (move_ready !== 1'b1) begin fails++; $display("FAIL init_ready: got %b expected 1", move_ready); end
    for (int i = 0; i < 4; i++) begin
      read_sq(addrs[i], d);
      $display("read sq=%0d data=%b", addrs[i], d);
      checks++; if (d !== exps[i]) begin fails++; $display("FAIL init_sq%0d: got %b expected %b", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_errors();
    int lat;
    logic err, rdy, dn;
    logic [3:0] cap, d;
    logic [5:0] srcs [4] = '{6'd52, 6'd20, 6'd10, 6'd60};
    logic [5:0] dsts [4] = '{6'd53, 6'd28, 6'd10, 6'd59};
    logic [5:0] addrs [5] = '{6'd52, 6'd53, 6'd10, 6'd60, 6'd20};
    logic [3:0] exps  [5] = '{4'b0001, 4'b0001, 4'b1001, 4'b0110, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, srcs[i], dsts[i], lat, err, cap, rdy, dn);
      checks++; if (lat !== 2) begin fails++; $display("FAIL err%0d_latency: got %0d expected 2", i, lat); end
      checks++; if (err !== 1'b1) begin fails++; $display("FAIL err%0d_move_err: got %b expected 1", i, err); end
      checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL err%0d_ready_after: got %b expected 1", i, rdy); end
      checks++; if (dn !== 1'b0) begin fails++; $display("FAIL err%0d_done_pulse: got %b expected 0", i, dn); end
    end
    for (int i = 0; i < 5; i++) begin
      read_sq(addrs[i], d);
      checks++; if (d !== exps[i]) begin fails++; $display("FAIL err_unchanged_sq%0d: got %b expected %b", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_legal_move();
    int lat;
    logic err, rdy, dn;
    logic [3:0] cap, d;
    run_op(1'b0, 6'd52, 6'd36, lat, err, cap, rdy, dn);
    checks++; if (lat !== 4) begin fails++; $display("FAIL move_latency: got %0d expected 4", lat); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL move_err: got %b expected 0", err); end
    checks++; if (cap !== 4'b0000) begin fails++; $display("FAIL move_captured: got %b expected 0000", cap); end
    checks++; if (rdy !== 1'b1 || dn !== 1'b0) begin fails++; $display("FAIL move_after: got ready=%b done=%b expected ready=1 done=0", rdy, dn); end
    read_sq(6'd36, d);
    checks++; if (d !== 4'b0001) begin fails++; $display("FAIL move_sq36: got %b expected 0001", d); end
    read_sq(6'd52, d);
    checks++; if (d !== 4'b0000) begin fails++; $display("FAIL move_sq52: got %b expected 0000", d); end
  endtask

  task automatic test_capture();
    int lat;
    logic err, rdy, dn;
    logic [3:0] cap, d;
    run_op(1'b0, 6'd12, 6'd28, lat, err, cap, rdy, dn);
    checks++; if (lat !== 4 || err !== 1'b0 || cap !== 4'b0000) begin fails++; $display("FAIL cap_setup: got lat=%0d err=%b cap=%b expected 4 0 0000", lat, err, cap); end
    run_op(1'b0, 6'd36, 6'd28, lat, err, cap, rdy, dn);
    checks++; if (lat !== 4) begin fails++; $display("FAIL cap_latency: got %0d expected 4", lat); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL cap_err: got %b expected 0", err); end
    checks++; if (cap !== 4'b1001) begin fails++; $display("FAIL cap_captured: got %b expected 1001", cap); end
    read_sq(6'd28, d);
    checks++; if (d !== 4'b0001) begin fails++; $display("FAIL cap_sq28: got %b expected 0001", d); end
    read_sq(6'd36, d);
    checks++; if (d !== 4'b0000) begin fails++; $display("FAIL cap_sq36: got %b expected 0000", d); end
    read_sq(6'd12, d);
    checks++; if (d !== 4'b0000) begin fails++; $display("FAIL cap_sq12: got %b expected 0000", d); end
    checks++; if (captured !== 4'b1001) begin fails++; $display("FAIL cap_hold: got %b expected 1001", captured); end
  endtask

`ifdef CHESS_BOARD_UNDO_EN
  task automatic test_undo();
    int lat;
    logic err, rdy, dn;
    logic [3:0] cap, d;
    checks++; if (undo_valid !== 1'b1) begin fails++; $display("FAIL undo_valid_before: got %b expected 1", undo_valid); end
    run_op(1'b1, 6'd0, 6'd0, lat, err, cap, rdy, dn);
    checks++; if (lat >= 20) begin fails++; $display("FAIL undo_timeout: got %0d edges expected done", lat); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL undo_err: got %b expected 0", err); end
    checks++; if (undo_valid !== 1'b0) begin fails++; $display("FAIL undo_valid_after: got %b expected 0", undo_valid); end
    read_sq(6'd36, d);
    checks++; if (d !== 4'b0001) begin fails++; $display("FAIL undo_sq36: got %b expected 0001", d); end
    read_sq(6'd28, d);
    checks++; if (d !== 4'b1001) begin fails++; $display("FAIL undo_sq28: got %b expected 1001", d); end
    run_op(1'b1, 6'd0, 6'd0, lat, err, cap, rdy, dn);
    checks++; if (lat >= 20 || err !== 1'b1) begin fails++; $display("FAIL undo_second: got lat=%0d err=%b expected err=1", lat, err); end
  endtask
`endif

  task automatic test_reset_mid_move();
    int n;
    logic [3:0] d;
    logic [5:0] addrs [5] = '{6'd36, 6'd28, 6'd51, 6'd43, 6'd12};
    logic [3:0] exps  [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1001};
    @(negedge ClkPort);
    move_src = 6'd51;
    move_dst = 6'd43;
    move_req = 1'b1;
    @(posedge ClkPort);
    #1;
    move_req = 1'b0;
    @(posedge ClkPort);
    #1;
    Reset = 1'b0;
    #1;
    $display("reset asserted mid-move");
    checks++; if (init_busy !== 1'b1) begin fails++; $display("FAIL midrst_init_busy: got %b expected 1", init_busy); end
    checks++; if (move_done !== 1'b0 || move_ready !== 1'b0) begin fails++; $display("FAIL midrst_flags: got done=%b ready=%b expected 0 0", move_done, move_ready); end
    checks++; if (rd_data !== 4'b0000) begin fails++; $display("FAIL midrst_rd_data: got %b expected 0000", rd_data); end
`ifdef CHESS_BOARD_UNDO_EN
    checks++; if (undo_valid !== 1'b0) begin fails++; $display("FAIL midrst_undo_valid: got %b expected 0", undo_valid); end
`endif
    @(negedge ClkPort);
    Reset = 1'b1;
    wait_init(n);
    checks++; if (n !== 64) begin fails++; $display("FAIL midrst_init_cycles: got %0d expected 64", n); end
    for (int i = 0; i < 5; i++) begin
      read_sq(addrs[i], d);
      checks++; if (d !== exps[i]) begin fails++; $display("FAIL midrst_sq%0d: got %b expected %b", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_clear();
    int lat, n;
    logic err, rdy, dn, sawDone;
    logic [3:0] cap, d;
    logic [5:0] addrs [4] = '{6'd36, 6'd52, 6'd45, 6'd53};
    logic [3:0] exps  [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};
    run_op(1'b0, 6'd52, 6'd36, lat, err, cap, rdy, dn);
    checks++; if (lat !== 4 || err !== 1'b0) begin fails++; $display("FAIL clr_setup: got lat=%0d err=%b expected 4 0", lat, err); end
    // clear_req and move_req together: clear wins; move_req stays high into INIT.
    @(negedge ClkPort);
    move_src  = 6'd53;
    move_dst  = 6'd45;
    move_req  = 1'b1;
    clear_req = 1'b1;
    @(posedge ClkPort);
    #1;
    clear_req = 1'b0;
    $display("clear requested");
    checks++; if (init_busy !== 1'b1 || move_ready !== 1'b0) begin fails++; $display("FAIL clr_enter: got busy=%b ready=%b expected 1 0", init_busy, move_ready); end
    n = 0;
    sawDone = 1'b0;
    do begin
      @(posedge ClkPort);
      #1;
      n++;
      if (move_done) sawDone = 1'b1;
      if (n == 30) move_req = 1'b0;
    end while (init_busy && n < 200);
    checks++; if (n !== 64) begin fails++; $display("FAIL clr_init_cycles: got %0d expected 64", n); end
    checks++; if (sawDone !== 1'b0) begin fails++; $display("FAIL clr_move_ignored: got done=%b expected 0", sawDone); end
    for (int i = 0; i < 4; i++) begin
      read_sq(addrs[i], d);
      checks++; if (d !== exps[i]) begin fails++; $display("FAIL clr_sq%0d: got %b expected %b", addrs[i], d, exps[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_errors();
    test_legal_move();
    test_capture();
`ifdef CHESS_BOARD_UNDO_EN
    test_undo();
`endif
    test_reset_mid_move();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
